count60_disp_ctrl: RTL

Controller for the mod-60 counter display path: it sequences counting and drives the 4-digit 7-segment display.
- Start/stop/clear FSM gates a prescaled 1 Hz count tick into a BCD MM:SS counter (00:00–59:59).
- A free-running scan scheduler time-shares the single a_to_g segment bus across the four an digit enables.
- Sits directly under top, between the board buttons (already debounced and pulsed upstream) and the display pins.

---
 rtl/count60_disp_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/count60_disp_ctrl.sv
// Mod-60 MM:SS counter with start/stop/clear sequencing and a
// time-multiplexed 4-digit 7-segment display driver.
module count60_disp_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk_50mHz,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic       run,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       rollover,
  output logic [6:0] a_to_g,
  output logic [3:0] an
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit;
  logic          tick;
  logic          at_max;
  logic [7:0]    nxt_sec;
  logic [7:0]    nxt_min;
  logic [3:0]    nib;
  logic [6:0]    seg;

  assign tick   = (state == RUN) && (presc == P_MAX);
  assign at_max = (sec_bcd == 8'h59) && (min_bcd == 8'h59);

  // BCD increment with carry chain sec ones -> sec tens -> min ones -> min tens
  always_comb begin
    nxt_sec = sec_bcd;
    nxt_min = min_bcd;
    if (sec_bcd[3:0] != 4'd9) begin
      nxt_sec[3:0] = sec_bcd[3:0] + 4'd1;
    end else begin
      nxt_sec[3:0] = 4'd0;
      if (sec_bcd[7:4] != 4'd5) begin
        nxt_sec[7:4] = sec_bcd[7:4] + 4'd1;
      end else begin
        nxt_sec[7:4] = 4'd0;
        if (min_bcd[3:0] != 4'd9) begin
          nxt_min[3:0] = min_bcd[3:0] + 4'd1;
        end else begin
          nxt_min[3:0] = 4'd0;
          if (min_bcd[7:4] != 4'd5) begin
            nxt_min[7:4] = min_bcd[7:4] + 4'd1;
          end else begin
            nxt_min[7:4] = 4'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      run      <= 1'b0;
      presc    <= '0;
      sec_bcd  <= 8'h00;
      min_bcd  <= 8'h00;
      rollover <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      run      <= 1'b0;
      presc    <= '0;
      sec_bcd  <= 8'h00;
      min_bcd  <= 8'h00;
      rollover <= 1'b0;
    end else begin
      rollover <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            run   <= 1'b1;
            presc <= '0;
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            sec_bcd  <= nxt_sec;
            min_bcd  <= nxt_min;
            rollover <= at_max;
          end
          // a tick on the same edge is still applied before pausing
          if (stop) begin
            state <= PAUSE;
            run   <= 1'b0;
          end
        end
        PAUSE: begin
          if (start && !stop) begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          run   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (scan_cnt == S_MAX) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_comb begin
    nib = 4'd0;
    unique case (digit)
      2'd0: nib = sec_bcd[3:0];
      2'd1: nib = sec_bcd[7:4];
      2'd2: nib = min_bcd[3:0];
      2'd3: nib = min_bcd[7:4];
      default: nib = 4'd0;
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    case (nib)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk_50mHz or negedge rst_n) begin
    if (!rst_n) begin
      an     <= 4'b1111;
      a_to_g <= 7'b1111111;
    end else begin
      an     <= ~(4'b0001 << digit);
      a_to_g <= seg;
    end
  end

endmodule
